ge_p3_tobytes: RTL and testbench

- Encodes an extended-coordinate point (X:Y:Z) into the 32-byte Ed25519 compressed form: s = tobytes(Y/Z), with the top bit of byte 31 XORed by isnegative(X/Z).
- Sits at the output of the point-arithmetic chain. Produces the rcheck encoding that the verifier compares against signature R.
- Does the Z inversion itself by square-and-multiply (Z^(p-2)) on the shared field multiplier, then two more multiplies and a combinational pack.

---
 rtl/ge_p3_tobytes_if.sv | 25 ++
 rtl/ge_p3_tobytes.sv | 134 +++++++++++++
 tb/tb_ge_p3_tobytes.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ge_p3_tobytes_if.sv
// Handshake and data bundle for the point encoder: start/result side plus
// the request/response lines to the shared field multiplier.
interface ge_p3_tobytes_if;
  logic         valid;
  logic [319:0] h_x;
  logic [319:0] h_y;
  logic [319:0] h_z;
  logic [255:0] s;
  logic         done;
  logic [319:0] mul_op_a;
  logic [319:0] mul_op_b;
  logic         mul_valid;
  logic [319:0] mul_res;
  logic         mul_done;

  modport slave (
    input  valid, h_x, h_y, h_z, mul_res, mul_done,
    output s, done, mul_op_a, mul_op_b, mul_valid
  );

  modport master (
    output valid, h_x, h_y, h_z, mul_res, mul_done,
    input  s, done, mul_op_a, mul_op_b, mul_valid
  );
endinterface

// File: rtl/ge_p3_tobytes.sv
// Ed25519 point compression: inverts Z by square-and-multiply on the shared
// multiplier, scales X and Y by 1/Z, then packs y with the sign of x.
module ge_p3_tobytes #(
  parameter logic [254:0] EXP = 255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffeb
) (
  input logic            clk,
  input logic            rst,
  ge_p3_tobytes_if.slave bus
);
  localparam logic [254:0] P = 255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
  // 512*p exceeds the magnitude of any signed 10-limb sum, so biasing makes it non-negative.
  localparam logic signed [265:0] BIAS = {2'b00, P, 9'b0};

  typedef enum logic [3:0] {
    IDLE, SQ, WAIT_SQ, MULZ, WAIT_MZ, MULX, WAIT_X, MULY, WAIT_Y, PACK
  } state_t;

  state_t       state;
  logic [7:0]   idx;
  logic [319:0] xl, yl, zl, acc, x, y;
  logic [255:0] enc;

  function automatic logic [255:0] fe_tobytes(input logic [319:0] f);
    logic signed [31:0]  limb;
    logic signed [265:0] t;
    logic signed [265:0] v;
    logic [265:0]        u;
    logic [255:0]        w;
    logic [255:0]        r;
    v = '0;
    for (int i = 0; i < 10; i++) begin
      limb = f[32*i +: 32];
      t    = limb;
      v    = v + (t <<< ((51 * i + 1) / 2));
    end
    v = v + BIAS;
    u = v;
    // Two folds of 2^255 = 19 (mod p) bring the value below 2^255, then one subtract.
    w = {1'b0, u[254:0]} + 256'(u[265:255]) * 256'd19;
    r = {1'b0, w[254:0]} + (w[255] ? 256'd19 : 256'd0);
    if (r >= {1'b0, P}) r = r - {1'b0, P};
    return r;
  endfunction

  function automatic logic [255:0] pack(input logic [319:0] fx, input logic [319:0] fy);
    logic [255:0] xb;
    logic [255:0] yb;
    xb = fe_tobytes(fx);
    yb = fe_tobytes(fy);
    return {yb[255] ^ xb[0], yb[254:0]};
  endfunction

  always_comb enc = pack(x, y);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      bus.done     <= 1'b0;
      bus.mul_valid <= 1'b0;
      bus.s        <= '0;
      bus.mul_op_a <= '0;
      bus.mul_op_b <= '0;
    end else begin
      bus.done      <= 1'b0;
      bus.mul_valid <= 1'b0;
      case (state)
        IDLE: if (bus.valid) begin
          xl    <= bus.h_x;
          yl    <= bus.h_y;
          zl    <= bus.h_z;
          acc   <= bus.h_z;
          idx   <= 8'd253;
          state <= SQ;
        end
        SQ: begin
          bus.mul_op_a  <= acc;
          bus.mul_op_b  <= acc;
          bus.mul_valid <= 1'b1;
          state         <= WAIT_SQ;
        end
        WAIT_SQ: if (bus.mul_done) begin
          acc <= bus.mul_res;
          if (EXP[idx]) state <= MULZ;
          else if (idx == 8'd0) state <= MULX;
          else begin
            idx   <= idx - 8'd1;
            state <= SQ;
          end
        end
        MULZ: begin
          bus.mul_op_a  <= acc;
          bus.mul_op_b  <= zl;
          bus.mul_valid <= 1'b1;
          state         <= WAIT_MZ;
        end
        WAIT_MZ: if (bus.mul_done) begin
          acc <= bus.mul_res;
          if (idx == 8'd0) state <= MULX;
          else begin
            idx   <= idx - 8'd1;
            state <= SQ;
          end
        end
        // acc now holds 1/Z; it stays put for both coordinate multiplies.
        MULX: begin
          bus.mul_op_a  <= xl;
          bus.mul_op_b  <= acc;
          bus.mul_valid <= 1'b1;
          state         <= WAIT_X;
        end
        WAIT_X: if (bus.mul_done) begin
          x     <= bus.mul_res;
          state <= MULY;
        end
        MULY: begin
          bus.mul_op_a  <= yl;
          bus.mul_op_b  <= acc;
          bus.mul_valid <= 1'b1;
          state         <= WAIT_Y;
        end
        WAIT_Y: if (bus.mul_done) begin
          y     <= bus.mul_res;
          state <= PACK;
        end
        PACK: begin
          bus.s    <= enc;
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ge_p3_tobytes.sv
// Bench for ge_p3_tobytes: a modular-arithmetic multiplier model with random
// latency and limb representation, and an integer reference for the encoding.
module tb_ge_p3_tobytes;
  localparam logic [254:0] P  = 255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
  localparam logic [254:0] BX = 255'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a;
  localparam logic [254:0] BY = 255'h6666666666666666666666666666666666666666666666666666666666666658;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ge_p3_tobytes_if bus();
  ge_p3_tobytes dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // multiplier model state
  logic         mdl_done = 1'b0;
  logic [319:0] mdl_res = '0;
  logic         stray_done = 1'b0;
  logic [319:0] stray_res = '0;
  logic         kill = 1'b0;
  int           lat_max = 1;
  int           mv_cnt = 0, md_cnt = 0, dn_cnt = 0, proto_err = 0;

  assign bus.mul_done = mdl_done | stray_done;
  assign bus.mul_res  = stray_done ? stray_res : mdl_res;

  function automatic int off(input int i);
    return (51 * i + 1) / 2;
  endfunction

  function automatic logic [254:0] fe2int(input logic [319:0] f);
    logic signed [299:0] v, t, pm;
    v  = '0;
    pm = {45'b0, P};
    for (int i = 0; i < 10; i++) begin
      t = $signed(f[32*i +: 32]);
      v = v + (t <<< off(i));
    end
    v = v % pm;
    if (v < 0) v = v + pm;
    return v[254:0];
  endfunction

  // mode 0: canonical, 1: value+p, 2: value-p (negative top limb)
  function automatic logic [319:0] int2fe(input logic [254:0] n, input int mode);
    logic signed [299:0] v, pm;
    logic [319:0] f;
    pm = {45'b0, P};
    v  = {45'b0, n};
    if (mode == 1) v = v + pm;
    if (mode == 2) v = v - pm;
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) f[32*i +: 32] = {6'b0, v[off(i) +: 26]};
      else            f[32*i +: 32] = {7'b0, v[off(i) +: 25]};
    end
    f[319:288] = v[261:230];
    return f;
  endfunction

  function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] pr;
    pr = {257'b0, a} * {257'b0, b};
    pr = pr % {257'b0, P};
    return pr[254:0];
  endfunction

  function automatic logic [254:0] modpow(input logic [254:0] b, input logic [254:0] e);
    logic [254:0] r, bb;
    r  = 255'd1;
    bb = b;
    for (int i = 0; i < 255; i++) begin
      if (e[i]) r = mulmod(r, bb);
      bb = mulmod(bb, bb);
    end
    return r;
  endfunction

  function automatic logic [255:0] ref_enc(input logic [319:0] fx, input logic [319:0] fy,
                                           input logic [319:0] fz);
    logic [254:0] zi, xa, ya;
    zi = modpow(fe2int(fz), P - 255'd2);
    xa = mulmod(fe2int(fx), zi);
    ya = mulmod(fe2int(fy), zi);
    return {xa[0], ya};
  endfunction

  function automatic logic [319:0] rand_limbs();
    logic [319:0] f;
    int r;
    for (int i = 0; i < 10; i++) begin
      r = int'($urandom) >>> 1;
      f[32*i +: 32] = r;
    end
    return f;
  endfunction

  function automatic logic [254:0] rand_fe();
    logic [255:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    r = r % {1'b0, P};
    return r[254:0];
  endfunction

  // Multiplier model plus protocol monitor, evaluated on the falling edge.
  logic [319:0] hold_a, hold_b, pend;
  int           cnt;
  logic         busy = 1'b0;
  always @(negedge clk) begin
    if (bus.mul_valid) mv_cnt++;
    if (bus.done) dn_cnt++;
    if (kill) begin
      busy     = 1'b0;
      mdl_done = 1'b0;
    end else begin
      mdl_done = 1'b0;
      if (busy) begin
        if (bus.mul_valid || bus.mul_op_a !== hold_a || bus.mul_op_b !== hold_b) proto_err++;
        cnt--;
        if (cnt == 0) begin
          mdl_done = 1'b1;
          mdl_res  = pend;
          busy     = 1'b0;
          md_cnt++;
        end
      end else if (bus.mul_valid) begin
        hold_a = bus.mul_op_a;
        hold_b = bus.mul_op_b;
        pend   = int2fe(mulmod(fe2int(hold_a), fe2int(hold_b)), int'($urandom_range(0, 2)));
        cnt    = (lat_max <= 1) ? 1 : int'($urandom_range(1, lat_max));
        busy   = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [319:0] fx, input logic [319:0] fy,
                     input logic [319:0] fz, input int lat, input int glitch,
                     output logic [255:0] got);
    int b_mv, b_dn, b_pe, b_md, n;
    lat_max = lat;
    @(negedge clk);
    b_mv = mv_cnt; b_dn = dn_cnt; b_pe = proto_err; b_md = md_cnt;
    bus.h_x = fx; bus.h_y = fy; bus.h_z = fz; bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    bus.h_x = rand_limbs(); bus.h_y = rand_limbs(); bus.h_z = rand_limbs();
    if (glitch > 0) begin
      n = 0;
      while (md_cnt - b_md < glitch && n < 20000) begin @(negedge clk); n++; end
      bus.h_x = int2fe(255'd0, 0); bus.h_y = int2fe(255'd1, 0); bus.h_z = int2fe(255'd1, 0);
      bus.valid = 1'b1;
      @(negedge clk);
      bus.valid = 1'b0;
    end
    n = 0;
    while (bus.done !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    check({tag, "_done"}, 256'(bus.done), 256'd1);
    got = bus.s;
    @(negedge clk);
    check({tag, "_done_pulse"}, 256'(bus.done), 256'd0);
    check({tag, "_s_hold"}, bus.s, got);
    @(negedge clk);
    check({tag, "_mul_reqs"}, 256'(mv_cnt - b_mv), 256'd508);
    check({tag, "_done_cnt"}, 256'(dn_cnt - b_dn), 256'd1);
    check({tag, "_protocol"}, 256'(proto_err - b_pe), 256'd0);
  endtask

  initial begin
    logic [319:0] fx, fy, fz;
    logic [255:0] got, b_enc;
    int b_mv, b_dn, b_md, n;
    bus.valid = 1'b0;
    bus.h_x = '0; bus.h_y = '0; bus.h_z = '0;

    repeat (2) @(negedge clk);
    check("rst_s", bus.s, 256'd0);
    check("rst_done", 256'(bus.done), 256'd0);
    check("rst_mul_valid", 256'(bus.mul_valid), 256'd0);
    check("rst_op_a", 256'(bus.mul_op_a), 256'd0);
    check("rst_op_b", 256'(bus.mul_op_b), 256'd0);
    rst = 1'b1;

    // identity
    fx = int2fe(255'd0, 0); fy = int2fe(255'd1, 0); fz = int2fe(255'd1, 0);
    run("ident", fx, fy, fz, 1, 0, got);
    check("ident_s", got, 256'd1);

    // projective scaling of the identity
    fx = int2fe(255'd0, 0); fy = int2fe(255'd2, 0); fz = int2fe(255'd2, 0);
    run("ident_z2", fx, fy, fz, 1, 0, got);
    check("ident_z2_s", got, 256'd1);

    // base point and its scaled / negated forms
    b_enc = 256'h6666666666666666666666666666666666666666666666666666666666666658;
    fx = int2fe(BX, 0); fy = int2fe(BY, 0); fz = int2fe(255'd1, 0);
    run("base", fx, fy, fz, 1, 0, got);
    check("base_s", got, b_enc);
    check("base_ref", ref_enc(fx, fy, fz), b_enc);

    fx = int2fe(mulmod(BX, 255'd3), 1); fy = int2fe(mulmod(BY, 255'd3), 2); fz = int2fe(255'd3, 0);
    run("base_z3", fx, fy, fz, 1, 0, got);
    check("base_z3_s", got, b_enc);

    fx = int2fe(P - BX, 0); fy = int2fe(BY, 0); fz = int2fe(255'd1, 0);
    run("neg_base", fx, fy, fz, 1, 0, got);
    check("neg_base_s", got, 256'he666666666666666666666666666666666666666666666666666666666666658);

    // Z = 0 gives a defined zero encoding
    fx = rand_limbs(); fy = rand_limbs(); fz = int2fe(255'd0, 2);
    run("z_zero", fx, fy, fz, 3, 0, got);
    check("z_zero_s", got, 256'd0);

    // base point with random multiplier latency
    fx = int2fe(BX, 2); fy = int2fe(BY, 1); fz = int2fe(255'd1, 1);
    run("base_lat", fx, fy, fz, 20, 0, got);
    check("base_lat_s", got, b_enc);

    // random points, unreduced signed limbs, random latency
    for (int k = 0; k < 2; k++) begin
      fx = rand_limbs(); fy = rand_limbs(); fz = rand_limbs();
      run("rand", fx, fy, fz, 20, 0, got);
      check("rand_s", got, ref_enc(fx, fy, fz));
    end
    fx = int2fe(rand_fe(), 2); fy = int2fe(rand_fe(), 1); fz = int2fe(rand_fe(), 0);
    run("rand_fe", fx, fy, fz, 2, 0, got);
    check("rand_fe_s", got, ref_enc(fx, fy, fz));

    // reset in the middle of the inversion
    lat_max = 4;
    @(negedge clk);
    b_md = md_cnt;
    bus.h_x = rand_limbs(); bus.h_y = rand_limbs(); bus.h_z = rand_limbs(); bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    n = 0;
    while (md_cnt - b_md < 100 && n < 20000) begin @(negedge clk); n++; end
    check("mid_rst_reached", 256'(md_cnt - b_md >= 100), 256'd1);
    rst = 1'b0; kill = 1'b1;
    @(negedge clk);
    check("mid_rst_mul_valid", 256'(bus.mul_valid), 256'd0);
    check("mid_rst_done", 256'(bus.done), 256'd0);
    check("mid_rst_s", bus.s, 256'd0);
    check("mid_rst_op_a", 256'(bus.mul_op_a), 256'd0);
    @(negedge clk);
    rst = 1'b1; kill = 1'b0;
    b_mv = mv_cnt; b_dn = dn_cnt;
    @(negedge clk);
    stray_res = rand_limbs(); stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (6) @(negedge clk);
    check("stray_no_req", 256'(mv_cnt - b_mv), 256'd0);
    check("stray_no_done", 256'(dn_cnt - b_dn), 256'd0);
    fx = int2fe(255'd0, 0); fy = int2fe(255'd1, 0); fz = int2fe(255'd1, 0);
    run("post_rst", fx, fy, fz, 1, 0, got);
    check("post_rst_s", got, 256'd1);

    // a second valid while busy must be ignored
    fx = int2fe(BX, 0); fy = int2fe(BY, 0); fz = int2fe(255'd1, 0);
    run("busy_valid", fx, fy, fz, 2, 50, got);
    check("busy_valid_s", got, b_enc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
